// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request, mthi/mtlo write and result bundle for mdu_iter
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             divz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             fault;

  modport master (
    output start, op, a, b, hi_we, lo_we, wd,
    input  busy, done, divz, hi, lo, fault
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wd,
    output busy, done, divz, hi, lo, fault
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit, fixed 33-edge latency, HI/LO registers
// DMR_CHECK_EN adds a lockstep shadow accumulator/counter that sets a sticky fault on mismatch.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   a_abs_q, a_abs_d;
  logic [WIDTH-1:0]   b_abs_q, b_abs_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;

  logic               a_in_neg, b_in_neg;
  logic [WIDTH-1:0]   a_in_abs, b_in_abs;
  logic [2*WIDTH-1:0] acc_init, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               div_zero;

  // Multiply keeps {partial, multiplier} and shifts right; divide keeps {remainder, dividend/quotient}
  // and shifts left, so one 2*WIDTH register serves both.
  function automatic logic [2*WIDTH-1:0] step(input logic               is_div,
                                               input logic [2*WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0]   a_abs,
                                               input logic [WIDTH-1:0]   b_abs);
    logic [WIDTH:0]     shl;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] r;
    shl = '0;
    sum = '0;
    if (is_div) begin
      shl = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      if (shl >= {1'b0, b_abs}) begin
        sum = shl - {1'b0, b_abs};
        r   = {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        r   = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_abs} : '0);
      r   = {sum, acc[WIDTH-1:1]};
    end
    return r;
  endfunction

  assign a_in_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_in_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_in_abs = a_in_neg ? -bus.a : bus.a;
  assign b_in_abs = b_in_neg ? -bus.b : bus.b;
  assign acc_init = {{WIDTH{1'b0}}, bus.op[1] ? a_in_abs : b_in_abs};

  // Sign fix-up: a_neg/b_neg are only ever set for the signed ops.
  assign div_zero = (b_abs_q == '0);
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
  assign quo_fix  = div_zero ? '1 :
                    ((a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem_fix  = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    a_abs_d  = a_abs_q;
    b_abs_d  = b_abs_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          busy_d   = 1'b1;
          is_div_d = bus.op[1];
          a_neg_d  = a_in_neg;
          b_neg_d  = b_in_neg;
          a_abs_d  = a_in_abs;
          b_abs_d  = b_in_abs;
          acc_d    = acc_init;
        end else begin
          if (bus.hi_we) hi_d = bus.wd;
          if (bus.lo_we) lo_d = bus.wd;
        end
      end
      S_RUN: begin
        acc_d = step(is_div_q, acc_q, a_abs_q, b_abs_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d   = rem_fix;
          lo_d   = quo_fix;
          divz_d = div_zero;
        end else begin
          hi_d   = prod_fix[2*WIDTH-1:WIDTH];
          lo_d   = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      a_abs_q  <= '0;
      b_abs_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      a_abs_q  <= a_abs_d;
      b_abs_q  <= b_abs_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

`ifdef DMR_CHECK_EN
  logic [2*WIDTH-1:0] sh_acc_q, sh_acc_d;
  logic [CW-1:0]      sh_cnt_q, sh_cnt_d;
  logic               fault_q, fault_d;

  // Shadow steps from the same latched operands; any divergence by FIX latches fault.
  always_comb begin
    sh_acc_d = sh_acc_q;
    sh_cnt_d = sh_cnt_q;
    fault_d  = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sh_acc_d = acc_init;
          sh_cnt_d = '0;
        end
      end
      S_RUN: begin
        sh_acc_d = step(is_div_q, sh_acc_q, a_abs_q, b_abs_q);
        sh_cnt_d = sh_cnt_q + 1'b1;
      end
      S_FIX: begin
        if ((sh_acc_q != acc_q) || (sh_cnt_q != cnt_q)) fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_acc_q <= '0;
      sh_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      sh_acc_q <= sh_acc_d;
      sh_cnt_q <= sh_cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.divz = divz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed and randomized checks of mdu_iter against an arithmetic model
`timescale 1ns/1ps
module tb_mdu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus ();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic        m_busy = 1'b0, m_done = 1'b0, m_divz = 1'b0, p_divz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_rem = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'h0;
        end else if (op == 2'b10) begin
          lo = sa / sb; hi = sa % sb;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // Model: an accepted op delivers its result 33 edges later; nothing else moves HI/LO meanwhile.
  always @(posedge clk) begin
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_divz = 1'b0; m_hi = '0; m_lo = '0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      m_divz = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_divz = p_divz;
        end
      end else if (bus.start) begin
        m_rem = 33;
        m_busy = 1'b1;
        model_op(bus.op, bus.a, bus.b, p_hi, p_lo, p_divz);
      end else begin
        if (bus.hi_we) m_hi = bus.wd;
        if (bus.lo_we) m_lo = bus.wd;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("done", 32'(bus.done), 32'(m_done));
      check("divz", 32'(bus.divz), 32'(m_divz));
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
`ifndef DMR_CHECK_EN
      check("fault", 32'(bus.fault), 32'h0);
`endif
    end
  end

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'($urandom_range(0, 15));
      4: v = -32'($urandom_range(1, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic wait_done(input string tag, output int edges, output int nbusy);
    int n;
    n = 1;
    nbusy = 32'(bus.busy);
    while (!bus.done && n < 45) begin
      @(negedge clk);
      n++;
      nbusy += 32'(bus.busy);
    end
    edges = n - 1;
    if (!bus.done) check({tag, "_timeout"}, 32'(edges), 32'd33);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    int edges, nbusy;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    wait_done(tag, edges, nbusy);
    check({tag, "_done_edge"}, 32'(edges), 32'd33);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd33);
    check({tag, "_hi"}, bus.hi, ehi);
    check({tag, "_lo"}, bus.lo, elo);
    check({tag, "_divz"}, 32'(bus.divz), 32'(edz));
    @(negedge clk);
  endtask

  initial begin
    int edges, nbusy, ndone;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_z",    2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_7",    2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // Second start at E5 must be dropped.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      bus.start = (k == 5);
      bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
      ndone += 32'(bus.done);
    end
    bus.start = 1'b0;
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_lo", bus.lo, 32'd15);
    check("busy_start_hi", bus.hi, 32'd0);

    bus.hi_we = 1'b1; bus.wd = 32'h1234_5678;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_done", 32'(bus.done), 32'h0);

    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    bus.lo_we = 1'b1; bus.wd = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check("start_wins_lo", bus.lo, 32'd15);
    bus.hi_we = 1'b1; bus.wd = 32'hAAAA_5555;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("busy_mthi_hi", bus.hi, 32'h1234_5678);
    wait_done("mtlo_race", edges, nbusy);
    check("mtlo_race_lo", bus.lo, 32'd6);
    check("mtlo_race_hi", bus.hi, 32'd0);
    @(negedge clk);

    // Reset asserted at E10 of a running op.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midrst_hi", bus.hi, 32'h0);
    check("midrst_lo", bus.lo, 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += 32'(bus.done);
    end
    check("midrst_ndone", 32'(ndone), 32'd0);

`ifdef DMR_CHECK_EN
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h0; bus.b = 32'h0;
    repeat (5) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    force dut.sh_acc_q[40] = 1'b1;
    @(negedge clk);
    release dut.sh_acc_q[40];
    wait_done("dmr", edges, nbusy);
    check("dmr_hi", bus.hi, 32'h0);
    check("dmr_lo", bus.lo, 32'h0);
    repeat (3) @(negedge clk);
    check("dmr_fault_held", 32'(bus.fault), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("dmr_fault_clr", 32'(bus.fault), 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op    = 2'($urandom_range(0, 3));
      bus.a     = pick();
      bus.b     = pick();
      bus.hi_we = ($urandom_range(0, 7) == 0);
      bus.lo_we = ($urandom_range(0, 7) == 0);
      bus.wd    = $urandom;
      reset     = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; reset = 1'b1;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
